// File: rtl/ex_unit_if.sv
// ex_unit_if: operand/result handshake bundle for the execute unit.
// master drives operations, slave is the execute unit.
interface ex_unit_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic             alu_src;
  logic             lui_src;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [WIDTH-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output flush, in_valid, alu_op, alu_src, lui_src,
    output rs1_data, rs2_data, imm, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  flush, in_valid, alu_op, alu_src, lui_src,
    input  rs1_data, rs2_data, imm, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/ex_unit.sv
// ex_unit: single-cycle ALU plus iterative shift-add multiplier
// behind a valid/ready handshake with a registered result.
module ex_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  ex_unit_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic               out_valid_q;
  logic               busy_q;
  logic               zero_q;
  logic [WIDTH-1:0]   result_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic               op_hi;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               lt_s;
  logic               lt_u;
  logic               is_mul;
  logic               accept;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   mul_res;

  assign op_a   = bus.lui_src ? '0 : bus.rs1_data;
  assign op_b   = bus.alu_src ? bus.imm : bus.rs2_data;
  assign shamt  = op_b[SW-1:0];
  assign lt_s   = $signed(op_a) < $signed(op_b);
  assign lt_u   = op_a < op_b;
  assign is_mul = (bus.alu_op == 4'd10) || (bus.alu_op == 4'd11);

  assign bus.in_ready = !bus.flush &&
    (state == IDLE || (state == DONE && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.zero      = zero_q;
  assign bus.result    = result_q;

  // One multiplier bit per step: add multiplicand into the upper
  // half when the current low bit is set, then shift right.
  assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {psum, prod[WIDTH-1:1]};
  assign mul_res = op_hi ? prod_next[2*WIDTH-1:WIDTH]
                         : prod_next[WIDTH-1:0];

  // Single-cycle ALU result for the operation being accepted.
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_a << shamt;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      4'd9:    alu_res = {{(WIDTH-1){1'b0}}, lt_u};
      default: alu_res = '0;
    endcase
  end

  // Control FSM with registered result, flags and multiplier state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      zero_q      <= 1'b1;
      result_q    <= '0;
      cnt         <= '0;
      mcand       <= '0;
      prod        <= '0;
      op_hi       <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == IDLE || bus.out_ready) begin
            if (accept && is_mul) begin
              state       <= MUL;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b1;
              cnt         <= CW'(WIDTH);
              mcand       <= op_a;
              prod        <= {{WIDTH{1'b0}}, op_b};
              op_hi       <= bus.alu_op[0];
            end else if (accept) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
            end else begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= mul_res;
            zero_q      <= (mul_res == '0);
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit: directed vector table, multi-cycle corner sequences
// and randomized ops checked against an arithmetic reference model.
module tb_ex_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_unit_if #(.WIDTH(W)) bus ();

  ex_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0]  op;
    logic        lui;
    logic        asrc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic lui,
                       input logic asrc, input logic [31:0] rs1,
                       input logic [31:0] rs2,
                       input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.lui_src  = lui;
    bus.alu_src  = asrc;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
    bus.imm      = imm;
  endtask

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int s;
    s = int'(b % 32);
    p = 64'(a) * 64'(b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: begin
        if (a[31]) return (a >> s) | ~(32'hFFFFFFFF >> s);
        return a >> s;
      end
      4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic bad;
    logic mul;
    int cyc;
    logic [3:0] op;
    logic lui, asrc;
    logic [31:0] r1, r2, im, a, b, e;

    tbl[0]  = '{4'd0,  0, 1, 32'hFFFFFFFF, 0, 1, 32'h0, 1};
    tbl[1]  = '{4'd0,  1, 1, 32'hDEADBEEF, 0,
                32'h12345000, 32'h12345000, 0};
    tbl[2]  = '{4'd1,  0, 0, 5, 7, 0, 32'hFFFFFFFE, 0};
    tbl[3]  = '{4'd7,  0, 0, 32'h80000000, 32'h24, 0,
                32'hF8000000, 0};
    tbl[4]  = '{4'd8,  0, 0, 32'hFFFFFFFF, 1, 0, 32'h1, 0};
    tbl[5]  = '{4'd9,  0, 0, 32'hFFFFFFFF, 1, 0, 32'h0, 1};
    tbl[6]  = '{4'd2,  0, 0, 32'hF0F01234, 32'h0FF0FFFF, 0,
                32'h00F01234, 0};
    tbl[7]  = '{4'd3,  0, 1, 32'hF0000000, 0, 32'hF,
                32'hF000000F, 0};
    tbl[8]  = '{4'd4,  0, 0, 32'hFFFF0000, 32'h0F0F0F0F, 0,
                32'hF0F00F0F, 0};
    tbl[9]  = '{4'd5,  0, 0, 1, 32'h21, 0, 32'h2, 0};
    tbl[10] = '{4'd6,  0, 0, 32'h80000000, 32'h1F, 0, 32'h1, 0};
    tbl[11] = '{4'd13, 0, 0, 32'h1234, 32'h5678, 0, 32'h0, 1};
    tbl[12] = '{4'd11, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,
                32'hFFFFFFFE, 0};
    tbl[13] = '{4'd10, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,
                32'h00000001, 0};
    tbl[14] = '{4'd12, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1};

    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_op   = '0;
    bus.alu_src  = 1'b0;
    bus.lui_src  = 1'b0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.imm      = '0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_result", 64'(bus.result), 0);
    chk("rst_zero", 64'(bus.zero), 1);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].op, tbl[i].lui, tbl[i].asrc,
            tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 1);
      tick();
      mul = (tbl[i].op == 4'd10) || (tbl[i].op == 4'd11);
      if (mul) begin
        bus.rs1_data = 32'h5A5A5A5A;
        bus.rs2_data = 32'h3;
        bad = 1'b0;
        repeat (W) begin
          if (!bus.busy || bus.out_valid || bus.in_ready) bad = 1'b1;
          tick();
        end
        chk($sformatf("vec%0d_busy_window", i), 64'(bad), 0);
      end
      chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 1);
      chk($sformatf("vec%0d_result", i), 64'(bus.result),
          64'(tbl[i].res));
      chk($sformatf("vec%0d_zero", i), 64'(bus.zero),
          64'(tbl[i].z));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("idle_out_valid", 64'(bus.out_valid), 0);

    drive(4'd0, 0, 1, 2, 0, 3);
    bus.out_ready = 1'b0;
    tick();
    chk("bp_first", 64'(bus.result), 5);
    drive(4'd0, 0, 1, 10, 0, 7);
    bad = 1'b0;
    repeat (5) begin
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd5 ||
          bus.zero !== 1'b0 || bus.in_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("bp_hold", 64'(bad), 0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 1);
    tick();
    chk("bp_next_result", 64'(bus.result), 17);
    chk("bp_next_valid", 64'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_idle", 64'(bus.out_valid), 0);

    drive(4'd10, 0, 0, 32'hFFFFFFFF, 3, 0);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    chk("fl_busy10", 64'(bus.busy), 1);
    bus.flush = 1'b1;
    drive(4'd0, 0, 1, 1, 0, 1);
    #1;
    chk("fl_in_ready", 64'(bus.in_ready), 0);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_busy", 64'(bus.busy), 0);
    chk("fl_out_valid", 64'(bus.out_valid), 0);
    bad = 1'b0;
    repeat (40) begin
      if (bus.out_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("fl_no_result", 64'(bad), 0);

    drive(4'd10, 0, 0, 7, 9, 0);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    chk("ar_busy", 64'(bus.busy), 0);
    chk("ar_out_valid", 64'(bus.out_valid), 0);
    chk("ar_result", 64'(bus.result), 0);
    chk("ar_zero", 64'(bus.zero), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.result !== '0) bad = 1'b1;
    end
    chk("ar_no_result", 64'(bad), 0);
    drive(4'd0, 0, 0, 2, 3, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("ar_add", 64'(bus.result), 5);
    chk("ar_add_valid", 64'(bus.out_valid), 1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) tick();
      op   = 4'($urandom_range(0, 15));
      lui  = ($urandom_range(0, 7) == 0);
      asrc = 1'($urandom_range(0, 1));
      r1   = pick();
      r2   = pick();
      im   = pick();
      a    = lui ? 32'd0 : r1;
      b    = asrc ? im : r2;
      e    = model(op, a, b);
      mul  = (op == 4'd10) || (op == 4'd11);
      drive(op, lui, asrc, r1, r2, im);
      tick();
      bus.in_valid = 1'b0;
      cyc = 0;
      while (!bus.out_valid && cyc < W + 4) begin
        tick();
        cyc++;
      end
      chk($sformatf("rnd%0d_op%0d_latency", n, op), 64'(cyc),
          mul ? 64'(W) : 64'd0);
      chk($sformatf("rnd%0d_op%0d_result", n, op),
          64'(bus.result), 64'(e));
      chk($sformatf("rnd%0d_op%0d_zero", n, op),
          64'(bus.zero), 64'(e == 32'd0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
